// File: rtl/led_rx_pkg.sv
// led_rx_pkg: shared encodings for the LED pixel receiver,
// its register block and the matching serializer.
package led_rx_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } rx_state_e;

  localparam int ERR_W       = 4;
  localparam int ERR_GLITCH  = 0;
  localparam int ERR_STUCK   = 1;
  localparam int ERR_PARTIAL = 2;
  localparam int ERR_OVF     = 3;

  localparam int WD_W       = 34;
  localparam int WD_PIX_LSB = 0;
  localparam int WD_PIX_MSB = 31;
  localparam int WD_SOF     = 32;
  localparam int WD_RSVD    = 33;

  localparam logic FMT_24 = 1'b0;
  localparam logic FMT_32 = 1'b1;

  function automatic logic [5:0] pix_bits(input logic fmt);
    return (fmt == FMT_24) ? 6'd24 : 6'd32;
  endfunction

endpackage

// File: rtl/led_rx_sync.sv
// led_rx_sync: multi-flop synchronizer for the LED data line
// with registered rise/fall detect aligned to the level output.
module led_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ser_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic dly_q, dly_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // shift chain plus one extra copy for edge compare
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ser_in};
    dly_d  = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & dly_q;
  end

  // synchronizer and edge registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = dly_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/led_rx.sv
// led_rx: WS2812-style NRZ pulse-width receiver; decodes bits,
// assembles 24/32-bit pixels and detects the latch (reset) code.
module led_rx
  import led_rx_pkg::*;
#(
  parameter int MIN_HIGH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             FORMAT,
  input  logic [7:0]       BIT_THRESH,
  input  logic [7:0]       RESET_CYCLE_TIMING,
  input  logic [7:0]       RESET_CODE_TIMING,
  input  logic             CLEAR,
  input  logic             SER_IN,
  input  logic             FIFO_FULL,
  output logic             FIFO_WE,
  output logic [WD_W-1:0]  FIFO_WDATA,
  output logic             EOF,
  output logic [ERR_W-1:0] ERR
);

  localparam logic [7:0] MIN_H = 8'(MIN_HIGH);

  logic lvl, rise, fall;

  rx_state_e state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] ucnt_q, ucnt_d;
  logic [5:0] bitcnt_q, bitcnt_d;
  logic [31:0] sh_q, sh_d;
  logic sof_q, sof_d;
  logic got_q, got_d;
  logic we_q, we_d;
  logic eof_q, eof_d;
  logic [WD_W-1:0] wdata_q, wdata_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [ERR_W-1:0] new_err;
  logic [7:0] code;
  logic [5:0] nbits;
  logic rst_code;
  logic bit_v;
  logic [31:0] sh_nx;
  logic [31:0] pix;

  led_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (CLK),
    .rst    (RST),
    .ser_in (SER_IN),
    .lvl    (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  // pulse timing, bit decode, pixel assembly and error flags
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    ucnt_d   = ucnt_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    sof_d    = sof_q;
    got_d    = got_q;
    we_d     = 1'b0;
    eof_d    = 1'b0;
    wdata_d  = wdata_q;
    new_err  = '0;
    rst_code = 1'b0;
    bit_v    = 1'b0;
    sh_nx    = '0;
    pix      = '0;
    code     = (RESET_CODE_TIMING == 8'd0) ? 8'd1 : RESET_CODE_TIMING;
    nbits    = pix_bits(FORMAT);

    if (rise) begin
      hcnt_d = 8'd1;
    end else if (lvl && hcnt_q != 8'hff) begin
      hcnt_d = hcnt_q + 8'd1;
    end

    // low timer parks at terminal count so detection fires once
    if (lvl) begin
      pcnt_d = '0;
      ucnt_d = '0;
    end else if (ucnt_q < code) begin
      if (pcnt_q == RESET_CYCLE_TIMING) begin
        pcnt_d   = '0;
        ucnt_d   = ucnt_q + 8'd1;
        rst_code = (ucnt_q + 8'd1 == code);
      end else begin
        pcnt_d = pcnt_q + 8'd1;
      end
    end

    unique case (state_q)
      ST_SYNC: begin
        if (rst_code) begin
          state_d  = ST_LOW;
          sof_d    = 1'b1;
          bitcnt_d = '0;
          sh_d     = '0;
          got_d    = 1'b0;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (rst_code) begin
          new_err[ERR_PARTIAL] = (bitcnt_q != 6'd0);
          eof_d    = got_q;
          sof_d    = 1'b1;
          bitcnt_d = '0;
          sh_d     = '0;
          got_d    = 1'b0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          if (hcnt_q < MIN_H) begin
            new_err[ERR_GLITCH] = 1'b1;
          end else begin
            bit_v = (hcnt_q > BIT_THRESH);
            sh_nx = {sh_q[30:0], bit_v};
            if (bitcnt_q + 6'd1 == nbits) begin
              pix      = (FORMAT == FMT_32) ? sh_nx
                                            : {8'h00, sh_nx[23:0]};
              got_d    = 1'b1;
              bitcnt_d = '0;
              sh_d     = '0;
              if (FIFO_FULL) begin
                new_err[ERR_OVF] = 1'b1;
              end else begin
                we_d                           = 1'b1;
                wdata_d[WD_PIX_MSB:WD_PIX_LSB] = pix;
                wdata_d[WD_SOF]                = sof_q;
                wdata_d[WD_RSVD]               = 1'b0;
                sof_d                          = 1'b0;
              end
            end else begin
              sh_d     = sh_nx;
              bitcnt_d = bitcnt_q + 6'd1;
            end
          end
        end else if (hcnt_q == 8'hff) begin
          new_err[ERR_STUCK] = 1'b1;
          state_d  = ST_SYNC;
          bitcnt_d = '0;
          sh_d     = '0;
          got_d    = 1'b0;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    err_d = (CLEAR ? '0 : err_q) | new_err;

    if (!ENABLE) begin
      state_d  = ST_SYNC;
      hcnt_d   = '0;
      pcnt_d   = '0;
      ucnt_d   = '0;
      bitcnt_d = '0;
      sh_d     = '0;
      sof_d    = 1'b0;
      got_d    = 1'b0;
      we_d     = 1'b0;
      eof_d    = 1'b0;
      err_d    = '0;
    end
  end

  // state and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_SYNC;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      ucnt_q   <= '0;
      bitcnt_q <= '0;
      sh_q     <= '0;
      sof_q    <= 1'b0;
      got_q    <= 1'b0;
      we_q     <= 1'b0;
      eof_q    <= 1'b0;
      wdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      ucnt_q   <= ucnt_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      sof_q    <= sof_d;
      got_q    <= got_d;
      we_q     <= we_d;
      eof_q    <= eof_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign FIFO_WE    = we_q;
  assign FIFO_WDATA = wdata_q;
  assign EOF        = eof_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_led_rx.sv
// tb_led_rx: randomized pulse-train stimulus for led_rx checked
// against a pulse/low-run level reference model.
module tb_led_rx;

  localparam int MIN_HIGH = 4;

  logic CLK = 1'b0;
  logic RST, ENABLE, FORMAT, CLEAR, SER_IN, FIFO_FULL;
  logic [7:0] BIT_THRESH, RESET_CYCLE_TIMING, RESET_CODE_TIMING;
  logic FIFO_WE, EOF;
  logic [33:0] FIFO_WDATA;
  logic [3:0] ERR;

  always #5 CLK = ~CLK;

  led_rx #(
    .MIN_HIGH(MIN_HIGH),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ENABLE(ENABLE),
    .FORMAT(FORMAT),
    .BIT_THRESH(BIT_THRESH),
    .RESET_CYCLE_TIMING(RESET_CYCLE_TIMING),
    .RESET_CODE_TIMING(RESET_CODE_TIMING),
    .CLEAR(CLEAR),
    .SER_IN(SER_IN),
    .FIFO_FULL(FIFO_FULL),
    .FIFO_WE(FIFO_WE),
    .FIFO_WDATA(FIFO_WDATA),
    .EOF(EOF),
    .ERR(ERR)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // observed writes and EOF pulses
  logic [33:0] obs_q[$];
  int eof_obs = 0;
  always @(negedge CLK) begin
    if (FIFO_WE === 1'b1) obs_q.push_back(FIFO_WDATA);
    if (EOF === 1'b1) eof_obs++;
  end

  // reference model state
  logic [33:0] exp_q[$];
  bit m_bits[$];
  int m_eof;
  logic [3:0] m_err;
  bit m_synced, m_sof, m_got;
  int low_run;
  int obs_rd = 0;
  int eof_base = 0;

  function automatic int n_rst();
    int c;
    c = (RESET_CODE_TIMING == 8'd0) ? 1 : int'(RESET_CODE_TIMING);
    return c * (int'(RESET_CYCLE_TIMING) + 1);
  endfunction

  task automatic m_clear();
    m_bits.delete();
    m_err = '0;
    m_synced = 0;
    m_sof = 0;
    m_got = 0;
    low_run = 0;
  endtask

  task automatic gap(input int n);
    int old;
    int nr;
    old = low_run;
    nr = n_rst();
    SER_IN = 1'b0;
    repeat (n) @(negedge CLK);
    low_run += n;
    if (old < nr && low_run >= nr) begin
      if (m_synced) begin
        if (m_bits.size() != 0) m_err[2] = 1'b1;
        if (m_got) m_eof++;
      end
      m_synced = 1;
      m_sof = 1;
      m_got = 0;
      m_bits.delete();
    end
  endtask

  task automatic pulse(input int h);
    longint unsigned px;
    SER_IN = 1'b1;
    repeat (h) @(negedge CLK);
    low_run = 0;
    if (!m_synced) return;
    if (h >= 256) begin
      m_err[1] = 1'b1;
      m_synced = 0;
      m_bits.delete();
    end else if (h < MIN_HIGH) begin
      m_err[0] = 1'b1;
    end else begin
      m_bits.push_back(h > int'(BIT_THRESH));
      if (m_bits.size() == (FORMAT ? 32 : 24)) begin
        px = 0;
        foreach (m_bits[i]) px = (px << 1) | longint'(m_bits[i]);
        m_got = 1;
        if (FIFO_FULL) m_err[3] = 1'b1;
        else begin
          exp_q.push_back({1'b0, m_sof, px[31:0]});
          m_sof = 0;
        end
        m_bits.delete();
      end
    end
  endtask

  task automatic sbit(input bit b);
    if (b) pulse($urandom_range(30, 45));
    else pulse($urandom_range(10, 22));
    gap($urandom_range(15, 40));
  endtask

  task automatic spix(input logic [31:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) sbit(v[i]);
  endtask

  task automatic cfg(input logic fmt, input logic [7:0] rct,
                     input logic [7:0] code);
    ENABLE = 1'b0;
    SER_IN = 1'b0;
    FIFO_FULL = 1'b0;
    repeat (3) @(negedge CLK);
    FORMAT = fmt;
    RESET_CYCLE_TIMING = rct;
    RESET_CODE_TIMING = code;
    m_clear();
    ENABLE = 1'b1;
  endtask

  task automatic clr_pulse();
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    m_err = '0;
    @(negedge CLK);
  endtask

  task automatic check_scn(input string tag);
    int nobs;
    int n;
    repeat (8) @(negedge CLK);
    nobs = obs_q.size() - obs_rd;
    chk({tag, "_nwr"}, 64'(nobs), 64'(exp_q.size()));
    n = (nobs < exp_q.size()) ? nobs : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_wdata"}, 64'(obs_q[obs_rd + i]), 64'(exp_q[i]));
    chk({tag, "_eof"}, 64'(eof_obs - eof_base), 64'(m_eof));
    chk({tag, "_err"}, 64'(ERR), 64'(m_err));
    obs_rd = obs_q.size();
    eof_base = eof_obs;
    exp_q.delete();
    m_eof = 0;
  endtask

  initial begin
    logic [31:0] v;
    logic [33:0] t1;
    int np;
    int gpos;
    RST = 1'b1;
    ENABLE = 1'b0;
    FORMAT = 1'b0;
    CLEAR = 1'b0;
    SER_IN = 1'b0;
    FIFO_FULL = 1'b0;
    BIT_THRESH = 8'd26;
    RESET_CYCLE_TIMING = 8'd44;
    RESET_CODE_TIMING = 8'd50;
    m_clear();
    m_eof = 0;
    repeat (3) @(negedge CLK);
    chk("rst_we", 64'(FIFO_WE), 64'd0);
    chk("rst_wdata", 64'(FIFO_WDATA), 64'd0);
    chk("rst_eof", 64'(EOF), 64'd0);
    chk("rst_err", 64'(ERR), 64'd0);
    RST = 1'b0;

    // fixed 24-bit pixel with nominal timing
    cfg(1'b0, 8'd44, 8'd50);
    gap(2300);
    v = 32'h00A5C30F;
    for (int i = 23; i >= 0; i--) begin
      pulse(v[i] ? 35 : 18);
      gap(v[i] ? 20 : 37);
    end
    gap(2300);
    repeat (8) @(negedge CLK);
    t1 = (obs_q.size() > obs_rd) ? obs_q[obs_rd] : '1;
    chk("t1_fixed", 64'(t1), 64'h1_00A5C30F);
    check_scn("t1");

    // two 32-bit pixels in one frame
    cfg(1'b1, 8'd44, 8'd50);
    gap(2300);
    spix(32'h11223344, 32);
    spix(32'hDEADBEEF, 32);
    gap(2300);
    check_scn("t2");

    // partial pixel at reset code, then CLEAR
    cfg(1'b0, 8'd44, 8'd50);
    gap(2300);
    spix($urandom, 12);
    gap(2300);
    check_scn("t3");
    clr_pulse();
    chk("t3_clear", 64'(ERR), 64'(m_err));

    // glitch mid-pixel
    cfg(1'b0, 8'd44, 8'd50);
    gap(2300);
    v = $urandom;
    spix(v >> 14, 10);
    pulse(2);
    gap(20);
    spix(v, 14);
    gap(2300);
    check_scn("t4");
    clr_pulse();

    // stuck-high, pixel ignored until next reset code
    gap(2300);
    pulse(300);
    gap(30);
    spix($urandom, 24);
    gap(2300);
    spix($urandom, 24);
    gap(2300);
    check_scn("t5");

    // overflow on second of three pixels
    cfg(1'b0, 8'd44, 8'd50);
    gap(2300);
    spix($urandom, 24);
    FIFO_FULL = 1'b1;
    spix($urandom, 24);
    FIFO_FULL = 1'b0;
    spix($urandom, 24);
    gap(2300);
    check_scn("t6");
    cfg(1'b0, 8'd44, 8'd50);
    chk("t6_en_clr", 64'(ERR), 64'd0);

    // ENABLE dropped mid-pixel discards everything
    cfg(1'b0, 8'd49, 8'd2);
    gap(120);
    spix($urandom, 10);
    cfg(1'b0, 8'd49, 8'd2);
    gap(120);
    check_scn("t7");

    // exact reset-code boundary, code 0 treated as 1
    cfg(1'b0, 8'd49, 8'd0);
    gap(60);
    spix($urandom, 23);
    pulse(35);
    gap(49);
    spix($urandom, 23);
    pulse(18);
    gap(50);
    check_scn("t8");

    // randomized frames, formats, timing and back-pressure
    for (int it = 0; it < 5; it++) begin
      cfg(1'($urandom_range(0, 1)), 8'($urandom_range(49, 60)),
          8'($urandom_range(0, 3)));
      gap(n_rst() + $urandom_range(0, 20));
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        FIFO_FULL = ($urandom_range(0, 3) == 0);
        v = $urandom;
        gpos = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
        for (int i = (FORMAT ? 31 : 23); i >= 0; i--) begin
          if (gpos != 0 && i == gpos) begin
            pulse($urandom_range(1, 3));
            gap(20);
          end
          sbit(v[i]);
        end
        FIFO_FULL = 1'b0;
      end
      gap(n_rst() + $urandom_range(0, 20));
      check_scn("rnd");
    end

    // asynchronous reset mid-frame
    spix($urandom, 5);
    pulse(2);
    gap(20);
    #3 RST = 1'b1;
    #1;
    chk("arst_err", 64'(ERR), 64'd0);
    chk("arst_wdata", 64'(FIFO_WDATA), 64'd0);
    chk("arst_we", 64'(FIFO_WE), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
